// File: rtl/encoder_16to4_seq_if.sv
// Output handshake bundle for encoder_16to4_seq.
//   code  : encoded index of the presented request (master -> slave)
//   valid : code is valid                           (master -> slave)
//   ready : consumer accepts code when valid&&ready (slave -> master)
interface encoder_16to4_seq_if #(
   parameter int CODE_W = 4
);
   logic [CODE_W-1:0] code;
   logic              valid;
   logic              ready;

   modport master (output code, output valid, input ready);
   modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/encoder_16to4_seq.sv
// Sequential 16-to-4 encoder.
// Request lines are merged into a pending register. One index at a time is
// presented on a valid/ready handshake, and the granted pending bit clears
// on acceptance.
//
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   en      : gates request capture and new grants
//   req     : request lines (N bits)
//   bus     : encoder_16to4_seq_if.master (code/valid out, ready in)
//   pending : current pending-request register
//   drop    : registered pulse, a request hit an already-pending bit
//
// Optional build macro ENCODER_ROUND_ROBIN_EN:
//   - defined: rotating priority, with the search starting after the last
//     accepted code.
//   - undefined: fixed priority, lowest index wins.
//
// Only N=16 / CODE_W=4 is supported.
module encoder_16to4_seq #(
   parameter int N      = 16,
   parameter int CODE_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [N-1:0]        req,
   encoder_16to4_seq_if.master bus,
   output logic [N-1:0]        pending,
   output logic                drop
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t            state, state_next;
   logic [CODE_W-1:0] code_q;
   logic [CODE_W-1:0] sel;
   logic [CODE_W-1:0] start;
   logic [CODE_W-1:0] idx;
   logic              accept;
   logic              grant;
   logic [N-1:0]      clr_mask;
   logic [N-1:0]      req_gated;
   logic [N-1:0]      pending_next;

`ifdef ENCODER_ROUND_ROBIN_EN
   logic [CODE_W-1:0] last_q;
   assign start = last_q + 1'b1;
`else
   assign start = '0;
`endif

   assign accept       = (state == PRESENT) && bus.ready;
   assign grant        = (state == IDLE) && en && (pending != '0);
   assign clr_mask     = accept ? ({{(N-1){1'b0}}, 1'b1} << code_q) : '0;
   assign req_gated    = en ? req : '0;
   // A request and a clear on the same bit in the same cycle leave the bit set.
   assign pending_next = (pending & ~clr_mask) | req_gated;

   // The scan visits offsets from high to low. The last hit is kept, so the
   // smallest offset from start wins.
   always_comb begin
      sel = '0;
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = start + CODE_W'(N - 1 - i);
         if (pending[idx]) sel = idx;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant)     state_next = PRESENT;
         PRESENT: if (bus.ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.valid = (state == PRESENT);
      bus.code  = code_q;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         drop    <= 1'b0;
         code_q  <= '0;
      end else begin
         pending <= pending_next;
         drop    <= en && |(req & pending & ~clr_mask);
         if (grant) code_q <= sel;
      end
   end

`ifdef ENCODER_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_q <= '1;
      else if (accept) last_q <= code_q;
   end
`endif

endmodule

// File: tb/tb_encoder_16to4_seq.sv
module tb_encoder_16to4_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] req;
   logic [15:0] pending;
   logic        drop;

   encoder_16to4_seq_if #(.CODE_W(4)) bus ();

   encoder_16to4_seq #(.N(16), .CODE_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .bus     (bus),
      .pending (pending),
      .drop    (drop)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_code;

   // Scoreboard: every accepted code is checked against the expected order.
   always @(negedge clk) begin
      if (rst_n && bus.valid && bus.ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_unexpected: got code=%0d, want no transfer", bus.code);
         end else begin
            exp_code = exp_q.pop_front();
            if (bus.code !== exp_code) begin
               fails++;
               $display("FAIL scoreboard_code: got %0d, want %0d", bus.code, exp_code);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; req = '0; bus.ready = 1'b0;
      #12;
      tests++;
      if ({bus.valid, bus.code, pending, drop} !== '0) begin
         fails++;
         $display("FAIL reset_state: got valid=%b code=%0d pending=%h drop=%b, want all 0",
                  bus.valid, bus.code, pending, drop);
      end
      tick();
      rst_n = 1'b1; en = 1'b1; req = 16'h00F0;
      tick();
      req = '0;
      tick();
      tests++;
      if (bus.valid !== 1'b1 || bus.code !== 4'd4 || pending !== 16'h00F0) begin
         fails++;
         $display("FAIL reset_setup: got valid=%b code=%0d pending=%h, want 1/4/00f0",
                  bus.valid, bus.code, pending);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.valid, bus.code, pending, drop} !== '0) begin
         fails++;
         $display("FAIL reset_midpresent: got valid=%b code=%0d pending=%h drop=%b, want all 0",
                  bus.valid, bus.code, pending, drop);
      end
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (bus.valid !== 1'b0 || pending !== 16'h0000) begin
            fails++;
            $display("FAIL reset_idle: got valid=%b pending=%h, want 0/0000", bus.valid, pending);
         end
      end
   endtask

   task automatic test_single();
      en = 1'b1; bus.ready = 1'b1; req = 16'h0020;
      exp_q.push_back(4'd5);
      tick();
      req = '0;
      tests++;
      if (pending !== 16'h0020 || bus.valid !== 1'b0) begin
         fails++;
         $display("FAIL single_capture: got pending=%h valid=%b, want 0020/0", pending, bus.valid);
      end
      tick();
      tests++;
      if (bus.valid !== 1'b1 || bus.code !== 4'd5) begin
         fails++;
         $display("FAIL single_latency: got valid=%b code=%0d, want 1/5", bus.valid, bus.code);
      end
      tick();
      tests++;
      if (bus.valid !== 1'b0 || pending !== 16'h0000 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL single_done: got valid=%b pending=%h left=%0d, want 0/0000/0",
                  bus.valid, pending, exp_q.size());
      end
   endtask

   task automatic test_priority();
      bus.ready = 1'b1; req = 16'h8101;
      exp_q.push_back(4'd0); exp_q.push_back(4'd8); exp_q.push_back(4'd15);
      tick();
      req = '0;
      tests++;
      if (pending !== 16'h8101 || bus.valid !== 1'b0) begin
         fails++;
         $display("FAIL prio_capture: got pending=%h valid=%b, want 8101/0", pending, bus.valid);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if (bus.valid !== ((i % 2) == 0)) begin
            fails++;
            $display("FAIL prio_valid_cycle%0d: got valid=%b, want %b", i, bus.valid, (i % 2) == 0);
         end
      end
      tests++;
      if (pending !== 16'h0000 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL prio_drain: got pending=%h left=%0d, want 0000/0", pending, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int ndrop = 0;
      bus.ready = 1'b0; req = 16'h0004;
      tick();
      req = '0;
      exp_q.push_back(4'd2);
      tick();
      tests++;
      if (bus.valid !== 1'b1 || bus.code !== 4'd2) begin
         fails++;
         $display("FAIL bp_present: got valid=%b code=%0d, want 1/2", bus.valid, bus.code);
      end
      req = 16'h0004;
      for (int i = 0; i < 5; i++) begin
         tick();
         req = '0;
         if (drop === 1'b1) ndrop++;
         tests++;
         if (bus.valid !== 1'b1 || bus.code !== 4'd2 || pending !== 16'h0004 || drop !== (i == 0)) begin
            fails++;
            $display("FAIL bp_hold%0d: got valid=%b code=%0d pending=%h drop=%b, want 1/2/0004/%b",
                     i, bus.valid, bus.code, pending, drop, i == 0);
         end
      end
      tests++;
      if (ndrop != 1) begin
         fails++;
         $display("FAIL bp_drop_count: got %0d, want 1", ndrop);
      end
      bus.ready = 1'b1;
      tick();
      tick();
      tests++;
      if (bus.valid !== 1'b0 || pending !== 16'h0000 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL bp_merged: got valid=%b pending=%h left=%0d, want 0/0000/0",
                  bus.valid, pending, exp_q.size());
      end
      bus.ready = 1'b0;
   endtask

   task automatic test_collision_enable();
      bus.ready = 1'b0; en = 1'b1; req = 16'h0008;
      tick();
      req = '0;
      exp_q.push_back(4'd3);
      tick();
      exp_q.push_back(4'd3);
      bus.ready = 1'b1; req = 16'h0008;
      tick();
      req = '0; bus.ready = 1'b0;
      tests++;
      if (bus.valid !== 1'b0 || pending !== 16'h0008 || drop !== 1'b0) begin
         fails++;
         $display("FAIL coll_setwins: got valid=%b pending=%h drop=%b, want 0/0008/0",
                  bus.valid, pending, drop);
      end
      tick();
      tests++;
      if (bus.valid !== 1'b1 || bus.code !== 4'd3) begin
         fails++;
         $display("FAIL coll_represent: got valid=%b code=%0d, want 1/3", bus.valid, bus.code);
      end
      en = 1'b0; req = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (pending !== 16'h0008 || drop !== 1'b0 || bus.valid !== 1'b1 || bus.code !== 4'd3) begin
            fails++;
            $display("FAIL en_low%0d: got pending=%h drop=%b valid=%b code=%0d, want 0008/0/1/3",
                     i, pending, drop, bus.valid, bus.code);
         end
      end
      en = 1'b1; req = '0; bus.ready = 1'b1;
      tick();
      tests++;
      if (bus.valid !== 1'b0 || pending !== 16'h0000) begin
         fails++;
         $display("FAIL coll_done: got valid=%b pending=%h, want 0/0000", bus.valid, pending);
      end
      bus.ready = 1'b0; req = 16'h0010;
      tick();
      en = 1'b0; req = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (bus.valid !== 1'b0 || pending !== 16'h0010) begin
            fails++;
            $display("FAIL en_nogrant%0d: got valid=%b pending=%h, want 0/0010", i, bus.valid, pending);
         end
      end
      exp_q.push_back(4'd4);
      en = 1'b1; bus.ready = 1'b1;
      tick(); tick();
      tests++;
      if (bus.valid !== 1'b0 || pending !== 16'h0000 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL en_resume: got valid=%b pending=%h left=%0d, want 0/0000/0",
                  bus.valid, pending, exp_q.size());
      end
      bus.ready = 1'b0;
   endtask

   task automatic test_priority_mode();
      bit done = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; en = 1'b1; req = 16'h0011; bus.ready = 1'b1;
`ifdef ENCODER_ROUND_ROBIN_EN
      exp_q.push_back(4'd0); exp_q.push_back(4'd4); exp_q.push_back(4'd0); exp_q.push_back(4'd4);
`else
      exp_q.push_back(4'd0); exp_q.push_back(4'd0); exp_q.push_back(4'd0);
`endif
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         if (exp_q.size() == 0) done = 1'b1;
      end
      bus.ready = 1'b0; req = '0;
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL mode_timeout: got %0d codes outstanding, want 0", exp_q.size());
      end
      exp_q.delete();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tests++;
      if (bus.valid !== 1'b0 || pending !== 16'h0000) begin
         fails++;
         $display("FAIL mode_cleanup: got valid=%b pending=%h, want 0/0000", bus.valid, pending);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation timeout, want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_backpressure();
      test_collision_enable();
      test_priority_mode();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_leftover: got %0d, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
